led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Parametrised successor to the fixed 4-LED one-hot rotator FSM.
- Drives an N_LEDS-wide LED bank with a selectable pattern. Patterns: rotate left, rotate right, ping-pong, bar fill/drain.
- Steps are paced by an internal prescaler, so the block runs directly from the board clock.
- Sits between the board clock/reset and the LED pins (led_io). Mode and enable come from switches or a control register.

Parameters:
- N_LEDS, 4, number of LEDs driven; legal range 2..32.
- PRESCALE, 50_000_000, clk cycles per pattern step while enabled; legal range >= 1 (1 = step every enabled cycle).
- CNT_W, $clog2(PRESCALE) (min 1), localparam, prescaler counter width.
- POS_W, $clog2(N_LEDS), localparam, position index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  1 = prescaler counts and the pattern advances; 0 = freeze (counter and pattern held).
- mode  input  2  pattern select, sampled on the step cycle: 00 ROT_L, 01 ROT_R, 10 PING, 11 FILL.
- led_io  output  N_LEDS  LED pattern; combinational decode of registered pos/mode.
- step_tick  output  1  registered one-cycle pulse, high in the cycle after each pattern advance.

Behaviour:
- Reset (reset=1 at a clk edge): cnt=0, pos=0, dir=UP, step_tick=0.
  - led_io = 1 (bit 0 only) in every mode.
  - Reset has priority over en and over an in-flight tick.
  - Mid-operation reset returns to this state on that edge.
- Prescaler:
  - When en=1: if cnt==PRESCALE-1 then cnt<=0 and tick=1 for that cycle, else cnt<=cnt+1.
  - When en=0: cnt holds and tick=0.
  - Tick period is exactly PRESCALE enabled cycles. Deasserting en pauses the count; re-asserting it resumes without clearing.
- Step rules, applied only on tick, with mode sampled in the tick cycle:
  - ROT_L: pos <= (pos==N_LEDS-1) ? 0 : pos+1.
  - ROT_R: pos <= (pos==0) ? N_LEDS-1 : pos-1.
  - PING / FILL, dir=UP: at pos==N_LEDS-1, dir<=DN and pos<=N_LEDS-2; otherwise pos+1.
  - PING / FILL, dir=DN: at pos==0, dir<=UP and pos<=1; otherwise pos-1.
  - End positions are not repeated, so the bounce period is 2*(N_LEDS-1) steps.
  - ROT modes leave dir unchanged.
- Output decode:
  - ROT_L, ROT_R, PING: led_io = one-hot, bit pos set.
  - FILL: led_io = bits [pos:0] set (bar of pos+1 LEDs).
- Mode change:
  - No reset of pos or dir; the new rule applies from the next tick.
  - led_io re-decodes immediately, because decode is combinational on mode.
  - Entering PING/FILL with dir=DN at pos=0 turns to pos=1 on the next tick (normal rule).
- step_tick <= tick, registered, so it goes high in the cycle after the advance.
- The FSM is pos plus dir; no illegal states are reachable. Any out-of-range pos (N_LEDS not a power of 2) steps to 0 on the next tick.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings ROT_L, ROT_R, PING, FILL;
  - direction constants UP=0, DN=1.
- Sub-module led_prescaler (parameter PRESCALE; ports clk, reset, en, tick). It is reusable for other timed LED and seven-segment blocks.
- Top level holds pos/dir stepping, output decode and the step_tick register.

Test Plan (N_LEDS=4, PRESCALE=4 unless stated):
- Reset then ROT_L: reset=1 for 2 cycles, en=1, mode=00 -> led_io 0001 until the first tick (4th enabled cycle), then 0010, 0100, 1000, 0001. step_tick pulses once per 4 cycles.
- ROT_R wrap: from reset, mode=01 -> 0001, 1000, 0100, 0010, 0001.
- PING bounce: mode=10 over 8 ticks -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100 (no repeated end value).
- FILL: mode=11 -> 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0011.
- en pause and mid-run reset:
  - At cnt=2, drop en for 10 cycles -> no led_io change, step_tick=0; after re-assert, the tick comes 2 cycles later.
  - Assert reset coincident with a tick -> led_io=0001, step_tick=0 on the next cycle.
- Mode switch and PRESCALE=1:
  - PING at pos=2, dir=DN, switch to ROT_L -> next step gives pos=3 (1000).
  - Separate build with PRESCALE=1, N_LEDS=8 -> ROT_L advances every enabled cycle and wraps 0x80 -> 0x01.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared constants for the LED sequencer: pattern mode encodings
// and bounce direction values.
package led_seq_pkg;

    localparam logic [1:0] ROT_L = 2'b00;
    localparam logic [1:0] ROT_R = 2'b01;
    localparam logic [1:0] PING  = 2'b10;
    localparam logic [1:0] FILL  = 2'b11;

    localparam logic UP = 1'b0;
    localparam logic DN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Enable-gated prescaler: emits a one-cycle tick every PRESCALE
// enabled clocks; the count pauses (not clears) while en is low.
module led_prescaler #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Parametrised LED pattern sequencer: rotate, ping-pong and bar
// patterns stepped by an internal prescaler from the board clock.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS   = 4,
    parameter int PRESCALE = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led_io,
    output logic              step_tick
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] PENULT = POS_W'(N_LEDS - 2);

    logic             tick;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_nxt;
    logic             dir;
    logic             dir_nxt;
    int               pos_idx;

    led_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        // Unused encodings (non power-of-2 banks) fall back to LED 0
        if (pos > LAST) begin
            pos_nxt = '0;
        end else begin
            case (mode)
                ROT_L: pos_nxt = (pos == LAST) ? '0 : pos + 1'b1;
                ROT_R: pos_nxt = (pos == '0) ? LAST : pos - 1'b1;
                default: begin
                    if (dir == UP) begin
                        if (pos == LAST) begin
                            dir_nxt = DN;
                            pos_nxt = PENULT;
                        end else begin
                            pos_nxt = pos + 1'b1;
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_nxt = UP;
                            pos_nxt = POS_W'(1);
                        end else begin
                            pos_nxt = pos - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos       <= '0;
            dir       <= UP;
            step_tick <= 1'b0;
        end else begin
            step_tick <= tick;
            if (tick) begin
                pos <= pos_nxt;
                dir <= dir_nxt;
            end
        end
    end

    assign pos_idx = int'(pos);

    always_comb begin
        led_io = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            led_io[i] = (mode == FILL) ? (i <= pos_idx) : (i == pos_idx);
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench: two sequencer builds (4 LEDs / prescale 4 and
// 8 LEDs / prescale 1) against a behavioural pattern model.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] led4;
    logic       tick4;
    logic [7:0] led8;
    logic       tick8;

    always #5 clk = ~clk;

    led_sequencer #(.N_LEDS(4), .PRESCALE(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .led_io   (led4),
        .step_tick(tick4)
    );

    led_sequencer #(.N_LEDS(8), .PRESCALE(1)) u_fast (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .led_io   (led8),
        .step_tick(tick8)
    );

    typedef struct {
        int pos;
        int dir;
        int ecnt;
        bit tick;
    } mstate_t;

    typedef struct packed {
        logic [3:0] led4;
        logic       tick4;
        logic [7:0] led8;
        logic       tick8;
    } exp_t;

    exp_t    sb[$];
    mstate_t s4, s8;
    int      tests = 0;
    int      fails = 0;
    int      cyc = 0;
    bit      done = 0;

    // Bounce is modelled as reflection off the ends of the bank
    function automatic mstate_t model_step(mstate_t s, int n, int p,
                                           bit rst, bit e, bit [1:0] m);
        mstate_t r = s;
        int st, np;
        r.tick = 0;
        if (rst) begin
            r.pos = 0; r.dir = 0; r.ecnt = 0;
            return r;
        end
        if (!e) return r;
        r.ecnt = s.ecnt + 1;
        if (s.ecnt % p != p - 1) return r;
        r.tick = 1;
        if (m == 2'd0) r.pos = (s.pos + 1) % n;
        else if (m == 2'd1) r.pos = (s.pos + n - 1) % n;
        else begin
            st = (s.dir != 0) ? -1 : 1;
            np = s.pos + st;
            if (np < 0 || np >= n) begin
                r.dir = (s.dir != 0) ? 0 : 1;
                r.pos = s.pos - st;
            end else begin
                r.pos = np;
            end
        end
        return r;
    endfunction

    function automatic longint model_led(int pos, bit [1:0] m);
        longint one = 1;
        if (m == 2'd3) return (one << (pos + 1)) - 1;
        return one << pos;
    endfunction

    task automatic drive(input bit r, input bit e, input bit [1:0] m);
        exp_t x;
        longint l4, l8;
        reset = r; en = e; mode = m;
        @(posedge clk);
        s4 = model_step(s4, 4, 4, r, e, m);
        s8 = model_step(s8, 8, 1, r, e, m);
        l4 = model_led(s4.pos, m);
        l8 = model_led(s8.pos, m);
        x.led4  = l4[3:0];
        x.tick4 = s4.tick;
        x.led8  = l8[7:0];
        x.tick8 = s8.tick;
        sb.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit e, input bit [1:0] m);
        for (int i = 0; i < n; i++) drive(1'b0, e, m);
    endtask

    initial begin : monitor
        exp_t x;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                tests += 4;
                if (led4 !== x.led4) begin
                    fails++;
                    $display("FAIL led4 cyc=%0d got=%b exp=%b", cyc, led4, x.led4);
                end
                if (tick4 !== x.tick4) begin
                    fails++;
                    $display("FAIL tick4 cyc=%0d got=%b exp=%b", cyc, tick4, x.tick4);
                end
                if (led8 !== x.led8) begin
                    fails++;
                    $display("FAIL led8 cyc=%0d got=%h exp=%h", cyc, led8, x.led8);
                end
                if (tick8 !== x.tick8) begin
                    fails++;
                    $display("FAIL tick8 cyc=%0d got=%b exp=%b", cyc, tick8, x.tick8);
                end
            end
        end
    end

    initial begin : stim
        s4 = '{0, 0, 0, 0};
        s8 = '{0, 0, 0, 0};
        reset = 1'b1; en = 1'b0; mode = 2'd0;
        @(negedge clk);
        #1;
        drive(1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 2'd0);
        run(20, 1'b1, 2'd0);
        drive(1'b1, 1'b0, 2'd1);
        run(20, 1'b1, 2'd1);
        drive(1'b1, 1'b0, 2'd2);
        run(40, 1'b1, 2'd2);
        drive(1'b1, 1'b0, 2'd3);
        run(40, 1'b1, 2'd3);
        // pause at cnt=2, then resume
        drive(1'b1, 1'b0, 2'd0);
        run(2, 1'b1, 2'd0);
        run(10, 1'b0, 2'd0);
        run(5, 1'b1, 2'd0);
        // reset on the cycle that would tick
        drive(1'b1, 1'b0, 2'd0);
        run(3, 1'b1, 2'd0);
        drive(1'b1, 1'b1, 2'd0);
        run(3, 1'b1, 2'd0);
        // PING to pos=2 going down, then switch to ROT_L
        drive(1'b1, 1'b0, 2'd2);
        run(16, 1'b1, 2'd2);
        run(8, 1'b1, 2'd0);
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(63) == 0, $urandom_range(3) != 0,
                  2'($urandom_range(3)));
        end
        @(negedge clk);
        #1;
        done = 1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d left exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
